frame_update_scheduler: RTL and testbench
=========================================

// Module: frame_update_scheduler
// PURPOSE
//  Sequences the per-frame game-state update (bird physics, pipe scroll, collision, ...) into vertical blanking.
//  Detects start-of-frame from the VGA timing generator's active-low vsync.
//  Grants one update engine at a time through a req/done handshake, with per-phase watchdog and overrun detection.
//  Sits between the VGA timing block and the game engines; every engine update is gated by this block's req.
// PARAMETERS
//  NUM_PHASES      3       number of update engines, serviced in index order 0..NUM_PHASES-1
//  FRAME_DIV       1       launch a sequence every FRAME_DIV frames (>=1)
//  TIMEOUT_CYCLES  100000  max clk cycles a phase may hold req without done
//  FRAME_CNT_W     16      width of frame counter
// PORTS
//  clk         in   1            system clock, 100 MHz
//  reset       in   1            synchronous, active-low reset
//  vsync       in   1            VGA vertical sync, active low, from timing generator (same clock source)
//  enable      in   1            1 = launch sequences; 0 = pause (frame_tick continues)
//  done        in   NUM_PHASES   engine i finished; only sampled while req[i]=1
//  clr_err     in   1            1-cycle pulse clears overrun and err_phase
//  req         out  NUM_PHASES   one-hot (or zero) grant to engine i
//  phase_idx   out  clog2(NUM_PHASES) (min 1)  index of active phase; 0 when idle
//  seq_busy    out  1            sequence in progress
//  seq_done    out  1            1-cycle pulse after last phase completes
//  frame_tick  out  1            1-cycle pulse per frame start
//  frame_cnt   out  FRAME_CNT_W  frames seen since reset; wraps to 0
//  overrun     out  1            sticky: frame start arrived while seq_busy
//  err_phase   out  NUM_PHASES   sticky: phase i was ended by watchdog
// BEHAVIOUR
//  - Reset (reset=0 at clk edge): all outputs 0, FSM IDLE, div/watchdog counters 0, vsync_d<=1. Reset mid-sequence drops req next edge.
//  - sof = vsync_d & ~vsync (vsync_d = vsync registered). At the edge closing an sof cycle: frame_tick<=1 (one cycle), frame_cnt++.
//  - Divider div_cnt counts sofs 0..FRAME_DIV-1; launch condition = sof & div_cnt==FRAME_DIV-1 & enable & FSM IDLE.
//  - Launch: same edge as frame_tick -> FSM RUN, phase_idx=0, req=1<<0, seq_busy=1, watchdog cleared.
//  - FSM states: IDLE, RUN. RUN holds exactly one req bit.
//  - Phase i ends at the edge where (req[i] & done[i]) or watchdog==TIMEOUT_CYCLES-1.
//    Ends by watchdog without done -> err_phase[i]<=1. done and timeout same cycle: done wins, no error.
//  - Phase end, i<NUM_PHASES-1: req shifts to bit i+1 at that edge (no gap), phase_idx=i+1, watchdog<=0.
//  - Phase end, i=NUM_PHASES-1: req<=0, seq_busy<=0, phase_idx<=0, seq_done<=1 for one cycle, FSM IDLE.
//  - done[j] with req[j]=0 ignored entirely.
//  - sof while RUN: overrun<=1, frame_tick and frame_cnt still update, div_cnt still advances.
//    Running sequence continues; no relaunch that frame.
//  - sof in the same cycle the last phase ends: FSM is not IDLE at that edge -> overrun set, no launch.
//  - enable=0: running sequence completes normally; no new launches; div_cnt keeps counting.
//  - clr_err clears sticky flags; a set event in the same cycle wins (flag stays 1).
//  - Watchdog width clog2(TIMEOUT_CYCLES+1); saturates, never wraps. frame_cnt wraps modulo 2^FRAME_CNT_W.
// STRUCTURE
//  - Shared package vga_sched_pkg:
//    state encoding (IDLE/RUN); VGA 640x480 timing constants (H total 800, V total 525, V active 480);
//    default TIMEOUT_CYCLES.
//  - Sub-module phase_watchdog: load/clear, count enable, terminal-count flag at TIMEOUT_CYCLES-1.
//  - Rest (edge detect, divider, FSM, sticky flags) stays in this module.
// TESTING
//  1. Reset held 5 cycles mid-RUN, vsync toggling -> req, all flags, frame_cnt = 0; no frame_tick during reset.
//  2. vsync 1->0 once, engines return done 3 cycles after req -> req=001,010,100 each 4 cycles; seq_done at cycle 13 after frame_tick; frame_cnt=1.
//  3. Phase 1 never answers, TIMEOUT_CYCLES=16 -> req[1] high exactly 16 cycles, err_phase=010, phase 2 still runs.
//  4. Engine 0 stalls across next vsync falling edge -> overrun=1, frame_tick pulses, no relaunch; clr_err -> overrun=0.
//  5. FRAME_DIV=3, 6 frames -> exactly 2 launches, on frames 3 and 6; frame_cnt=6.
//  6. enable=0 mid-sequence -> sequence finishes with seq_done; next 2 frames no req; spurious done[2] while idle ignored.

Source files
------------

// File: rtl/vga_sched_pkg.sv
// Shared definitions for the frame update scheduler: FSM encoding, VGA 640x480
// timing constants and the default watchdog limit.
package vga_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    // 640x480 @ 60 Hz timing, used by neighbours to place the update window.
    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase cycle counter: cleared on phase start, counts while a phase is granted,
// saturates at TIMEOUT_CYCLES and flags the last permitted cycle.
module phase_watchdog #(
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic count_en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i && (count_q != CNT_W'(TIMEOUT_CYCLES))) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/frame_update_scheduler.sv
// Launches one pass over the game update engines per FRAME_DIV frames, starting at
// the vsync falling edge, granting engines one at a time with watchdog and overrun flags.
module frame_update_scheduler
    import vga_sched_pkg::*;
#(
    parameter int NUM_PHASES     = 3,
    parameter int FRAME_DIV      = 1,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int FRAME_CNT_W    = 16,
    localparam int PIDX_W = clog2_min1(NUM_PHASES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vsync,
    input  logic                   enable,
    input  logic [NUM_PHASES-1:0]  done,
    input  logic                   clr_err,
    output logic [NUM_PHASES-1:0]  req,
    output logic [PIDX_W-1:0]      phase_idx,
    output logic                   seq_busy,
    output logic                   seq_done,
    output logic                   frame_tick,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   overrun,
    output logic [NUM_PHASES-1:0]  err_phase,
    output sched_state_e           dbg_state_o
);

    localparam int DIV_W = clog2_min1(FRAME_DIV);

    sched_state_e           state_q;
    logic                   vsync_q;
    logic [NUM_PHASES-1:0]  req_q;
    logic [PIDX_W-1:0]      phase_q;
    logic                   busy_q;
    logic                   seq_done_q;
    logic                   tick_q;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic                   overrun_q, overrun_d;
    logic [NUM_PHASES-1:0]  err_q, err_d;

    logic sof;
    logic div_term;
    logic launch;
    logic done_hit;
    logic wd_tc;
    logic phase_end;
    logic timeout_end;
    logic last_phase;

    assign sof         = vsync_q & ~vsync;
    assign div_term    = (div_q == DIV_W'(FRAME_DIV - 1));
    assign launch      = sof & div_term & enable & (state_q == ST_IDLE);
    // req is one-hot in RUN, so this picks out done of the granted engine only.
    assign done_hit    = |(req_q & done);
    assign phase_end   = (state_q == ST_RUN) & (done_hit | wd_tc);
    assign timeout_end = (state_q == ST_RUN) & wd_tc & ~done_hit;
    assign last_phase  = (phase_q == PIDX_W'(NUM_PHASES - 1));

    phase_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (launch | phase_end),
        .count_en_i(state_q == ST_RUN),
        .tc_o      (wd_tc)
    );

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        if (sof) begin
            cnt_d = cnt_q + FRAME_CNT_W'(1);
            div_d = div_term ? '0 : div_q + DIV_W'(1);
        end
    end

    // Sticky flags: a set event in the same cycle as clr_err keeps the flag high.
    always_comb begin
        overrun_d = overrun_q & ~clr_err;
        if (sof && (state_q == ST_RUN)) begin
            overrun_d = 1'b1;
        end
        err_d = err_q & ~{NUM_PHASES{clr_err}};
        if (timeout_end) begin
            err_d = err_d | req_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            vsync_q    <= 1'b1;
            req_q      <= '0;
            phase_q    <= '0;
            busy_q     <= 1'b0;
            seq_done_q <= 1'b0;
            tick_q     <= 1'b0;
            cnt_q      <= '0;
            div_q      <= '0;
            overrun_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            vsync_q    <= vsync;
            tick_q     <= sof;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            overrun_q  <= overrun_d;
            err_q      <= err_d;
            seq_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        state_q <= ST_RUN;
                        req_q   <= NUM_PHASES'(1);
                        phase_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (phase_end) begin
                        if (last_phase) begin
                            state_q    <= ST_IDLE;
                            req_q      <= '0;
                            phase_q    <= '0;
                            busy_q     <= 1'b0;
                            seq_done_q <= 1'b1;
                        end else begin
                            req_q   <= req_q << 1;
                            phase_q <= phase_q + PIDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= '0;
                    phase_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req         = req_q;
    assign phase_idx   = phase_q;
    assign seq_busy    = busy_q;
    assign seq_done    = seq_done_q;
    assign frame_tick  = tick_q;
    assign frame_cnt   = cnt_q;
    assign overrun     = overrun_q;
    assign err_phase   = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Bench for frame_update_scheduler: two instances (FRAME_DIV 1 and 3, short watchdog)
// share stimulus; a step-level reference model checks every cycle, plus directed cases.
module tb_frame_update_scheduler;

    localparam int T = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic vsync = 1'b1;
    logic enable = 1'b1;
    logic clr_err = 1'b0;
    logic [2:0] done = 3'b000;

    logic [2:0]  req_o  [2];
    logic [1:0]  pidx_o [2];
    logic        busy_o [2];
    logic        sd_o   [2];
    logic        tick_o [2];
    logic [15:0] cnt_o  [2];
    logic        ov_o   [2];
    logic [2:0]  err_o  [2];
    logic        st_o   [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    frame_update_scheduler #(.NUM_PHASES(3), .FRAME_DIV(1), .TIMEOUT_CYCLES(T), .FRAME_CNT_W(16)) u_div1 (
        .clk(clk), .reset(reset), .vsync(vsync), .enable(enable), .done(done), .clr_err(clr_err),
        .req(req_o[0]), .phase_idx(pidx_o[0]), .seq_busy(busy_o[0]), .seq_done(sd_o[0]),
        .frame_tick(tick_o[0]), .frame_cnt(cnt_o[0]), .overrun(ov_o[0]), .err_phase(err_o[0]),
        .dbg_state_o(st_o[0])
    );

    frame_update_scheduler #(.NUM_PHASES(3), .FRAME_DIV(3), .TIMEOUT_CYCLES(T), .FRAME_CNT_W(16)) u_div3 (
        .clk(clk), .reset(reset), .vsync(vsync), .enable(enable), .done(done), .clr_err(clr_err),
        .req(req_o[1]), .phase_idx(pidx_o[1]), .seq_busy(busy_o[1]), .seq_done(sd_o[1]),
        .frame_tick(tick_o[1]), .frame_cnt(cnt_o[1]), .overrun(ov_o[1]), .err_phase(err_o[1]),
        .dbg_state_o(st_o[1])
    );

    // ---------------- reference model ----------------
    int          divs  [2] = '{1, 3};
    int          m_run [2];
    int          m_ph  [2];
    int          m_wd  [2];
    int          m_div [2];
    logic [15:0] m_cnt [2];
    logic        m_prev[2];
    logic        m_tick[2];
    logic        m_sd  [2];
    logic        m_ov  [2];
    logic [2:0]  m_err [2];

    task automatic model_step(input int k);
        logic sof, hit, ov_set, launch;
        logic [2:0] eset;
        if (!reset) begin
            m_run[k] = 0; m_ph[k] = 0; m_wd[k] = 0; m_div[k] = 0; m_cnt[k] = '0;
            m_prev[k] = 1'b1; m_tick[k] = 1'b0; m_sd[k] = 1'b0; m_ov[k] = 1'b0; m_err[k] = '0;
            return;
        end
        sof    = m_prev[k] & ~vsync;
        launch = sof && (m_div[k] == divs[k] - 1) && enable && (m_run[k] == 0);
        ov_set = sof && (m_run[k] != 0);
        eset   = '0;
        m_sd[k]   = 1'b0;
        m_tick[k] = sof;
        if (sof) begin
            m_cnt[k] = m_cnt[k] + 16'd1;
            m_div[k] = (m_div[k] + 1) % divs[k];
        end
        if (m_run[k] != 0) begin
            hit = done[m_ph[k]];
            if (hit || m_wd[k] == T - 1) begin
                if (!hit) eset[m_ph[k]] = 1'b1;
                m_wd[k] = 0;
                if (m_ph[k] == 2) begin
                    m_run[k] = 0; m_ph[k] = 0; m_sd[k] = 1'b1;
                end else begin
                    m_ph[k] = m_ph[k] + 1;
                end
            end else if (m_wd[k] < T) begin
                m_wd[k] = m_wd[k] + 1;
            end
        end else if (launch) begin
            m_run[k] = 1; m_ph[k] = 0; m_wd[k] = 0;
        end
        m_ov[k]  = ov_set | (m_ov[k] & ~clr_err);
        m_err[k] = eset | (m_err[k] & ~{3{clr_err}});
        m_prev[k] = vsync;
    endtask

    task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL u%0d %s: got %0h expected %0h at %0t", k, name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        for (int k = 0; k < 2; k++) begin
            chk(k, "req",   32'(req_o[k]),  (m_run[k] != 0) ? (32'd1 << m_ph[k]) : 32'd0);
            chk(k, "pidx",  32'(pidx_o[k]), 32'(m_ph[k]));
            chk(k, "busy",  32'(busy_o[k]), 32'(m_run[k] != 0));
            chk(k, "state", 32'(st_o[k]),   32'(m_run[k] != 0));
            chk(k, "sdone", 32'(sd_o[k]),   32'(m_sd[k]));
            chk(k, "tick",  32'(tick_o[k]), 32'(m_tick[k]));
            chk(k, "cnt",   32'(cnt_o[k]),  32'(m_cnt[k]));
            chk(k, "ovr",   32'(ov_o[k]),   32'(m_ov[k]));
            chk(k, "err",   32'(err_o[k]),  32'(m_err[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_model();
    endtask

    task automatic frame_fall();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        step();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        vs;
        logic [2:0]  dn;
        logic [2:0]  e_req;
        logic        e_busy;
        logic        e_tick;
        logic        e_sd;
        logic [15:0] e_cnt;
        logic [1:0]  e_pidx;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic rst, input logic vs, input logic [2:0] dn,
                                input logic [2:0] rq, input logic bz, input logic tk,
                                input logic sd, input logic [15:0] cn, input logic [1:0] pi);
        vec_t v;
        v.rst = rst; v.vs = vs; v.dn = dn; v.e_req = rq; v.e_busy = bz;
        v.e_tick = tk; v.e_sd = sd; v.e_cnt = cn; v.e_pidx = pi;
        return v;
    endfunction

    initial begin
        int c;
        logic [5:0] launch_mask;
        int launches;
        logic any_req;

        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_ph[k] = 0; m_wd[k] = 0; m_div[k] = 0; m_cnt[k] = '0;
            m_prev[k] = 1'b1; m_tick[k] = 1'b0; m_sd[k] = 1'b0; m_ov[k] = 1'b0; m_err[k] = '0;
        end

        // Single launch, engines answer in the 4th granted cycle.
        tbl[0]  = mk(0, 1, 3'b000, 3'b000, 0, 0, 0, 16'd0, 2'd0);
        tbl[1]  = mk(1, 1, 3'b000, 3'b000, 0, 0, 0, 16'd0, 2'd0);
        tbl[2]  = mk(1, 0, 3'b000, 3'b001, 1, 1, 0, 16'd1, 2'd0);
        tbl[3]  = mk(1, 0, 3'b000, 3'b001, 1, 0, 0, 16'd1, 2'd0);
        tbl[4]  = mk(1, 0, 3'b000, 3'b001, 1, 0, 0, 16'd1, 2'd0);
        tbl[5]  = mk(1, 0, 3'b000, 3'b001, 1, 0, 0, 16'd1, 2'd0);
        tbl[6]  = mk(1, 0, 3'b001, 3'b010, 1, 0, 0, 16'd1, 2'd1);
        tbl[7]  = mk(1, 0, 3'b000, 3'b010, 1, 0, 0, 16'd1, 2'd1);
        tbl[8]  = mk(1, 0, 3'b000, 3'b010, 1, 0, 0, 16'd1, 2'd1);
        tbl[9]  = mk(1, 0, 3'b000, 3'b010, 1, 0, 0, 16'd1, 2'd1);
        tbl[10] = mk(1, 0, 3'b010, 3'b100, 1, 0, 0, 16'd1, 2'd2);
        tbl[11] = mk(1, 0, 3'b000, 3'b100, 1, 0, 0, 16'd1, 2'd2);
        tbl[12] = mk(1, 0, 3'b000, 3'b100, 1, 0, 0, 16'd1, 2'd2);
        tbl[13] = mk(1, 0, 3'b000, 3'b100, 1, 0, 0, 16'd1, 2'd2);
        tbl[14] = mk(1, 0, 3'b100, 3'b000, 0, 0, 1, 16'd1, 2'd0);
        tbl[15] = mk(1, 1, 3'b000, 3'b000, 0, 0, 0, 16'd1, 2'd0);

        for (int i = 0; i < 16; i++) begin
            reset = tbl[i].rst;
            vsync = tbl[i].vs;
            done  = tbl[i].dn;
            step();
            chk(0, "tbl_req",  32'(req_o[0]),  32'(tbl[i].e_req));
            chk(0, "tbl_busy", 32'(busy_o[0]), 32'(tbl[i].e_busy));
            chk(0, "tbl_tick", 32'(tick_o[0]), 32'(tbl[i].e_tick));
            chk(0, "tbl_sd",   32'(sd_o[0]),   32'(tbl[i].e_sd));
            chk(0, "tbl_cnt",  32'(cnt_o[0]),  32'(tbl[i].e_cnt));
            chk(0, "tbl_pidx", 32'(pidx_o[0]), 32'(tbl[i].e_pidx));
        end
        done = 3'b000;

        // Phase 1 never answers: watchdog ends it after exactly T cycles.
        frame_fall();
        chk(0, "t3_launch", 32'(req_o[0]), 32'd1);
        done = 3'b001;
        step();
        done = 3'b000;
        c = 0;
        for (int i = 0; i < 40 && req_o[0] == 3'b010; i++) begin
            c++;
            step();
        end
        chk(0, "t3_req1_len", 32'(c), 32'(T));
        chk(0, "t3_err",      32'(err_o[0]), 32'b010);
        chk(0, "t3_phase2",   32'(req_o[0]), 32'b100);
        done = 3'b100;
        step();
        done = 3'b000;
        chk(0, "t3_sdone", 32'(sd_o[0]), 32'd1);

        // Engine 0 stalls across the next frame start.
        frame_fall();
        chk(0, "t4_launch", 32'(req_o[0]), 32'b001);
        repeat (3) step();
        frame_fall();
        chk(0, "t4_overrun", 32'(ov_o[0]),   32'd1);
        chk(0, "t4_tick",    32'(tick_o[0]), 32'd1);
        chk(0, "t4_norelnch", 32'(req_o[0]), 32'b001);
        done = 3'b111;
        repeat (3) step();
        done = 3'b000;
        chk(0, "t4_sdone", 32'(sd_o[0]), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk(0, "t4_clr_ovr", 32'(ov_o[0]),  32'd0);
        chk(0, "t4_clr_err", 32'(err_o[0]), 32'd0);

        // Reset held mid-sequence with vsync toggling.
        frame_fall();
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vsync = ~vsync;
            step();
            chk(0, "t1_req",  32'(req_o[0]),  32'd0);
            chk(0, "t1_tick", 32'(tick_o[0]), 32'd0);
            chk(0, "t1_cnt",  32'(cnt_o[0]),  32'd0);
            chk(0, "t1_busy", 32'(busy_o[0]), 32'd0);
        end
        reset = 1'b1;
        vsync = 1'b1;
        step();

        // FRAME_DIV=3 instance launches on frames 3 and 6.
        done = 3'b111;
        launch_mask = '0;
        launches = 0;
        for (int f = 0; f < 6; f++) begin
            frame_fall();
            if (busy_o[1]) begin
                launch_mask[f] = 1'b1;
                launches++;
            end
            repeat (5) step();
        end
        chk(1, "t5_mask",     32'(launch_mask), 32'b100100);
        chk(1, "t5_launches", 32'(launches),    32'd2);
        chk(1, "t5_cnt",      32'(cnt_o[1]),    32'd6);
        done = 3'b000;

        // enable dropped mid-sequence; spurious done while idle.
        frame_fall();
        step();
        enable = 1'b0;
        done = 3'b111;
        repeat (3) step();
        chk(0, "t6_sdone", 32'(sd_o[0]), 32'd1);
        done = 3'b100;
        any_req = 1'b0;
        for (int f = 0; f < 2; f++) begin
            frame_fall();
            any_req |= |req_o[0];
            for (int i = 0; i < 4; i++) begin
                step();
                any_req |= |req_o[0];
            end
        end
        chk(0, "t6_no_req", 32'(any_req), 32'd0);
        chk(0, "t6_err",    32'(err_o[0]), 32'd0);
        done = 3'b000;
        enable = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 8) vsync = ~vsync;
            done[0] = ($urandom_range(0, 3) == 0);
            done[1] = ($urandom_range(0, 3) == 0);
            done[2] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            clr_err = ($urandom_range(0, 99) < 3);
            reset = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
